lfsr_capture_packer: RTL and testbench

Downstream capture stage of the online-adder hardware test harness. Sits between the adder under test and the Avalon-MM write master. Gates the LFSR stimulus enable, captures one adder result (`{cout, dout}`) per enabled cycle, and tags each result with a sequence index into a 32-bit word. Buffers words in a small FIFO and streams them into the write master's user buffer, sequencing the master's `control_go` / `control_done` handshake for a run of N samples.

---
 rtl/lfsr_capture_packer.sv | 155 +++++++++++++++
 tb/tb_lfsr_capture_packer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_capture_packer.sv
// Capture stage for the online-adder test harness: gates the stimulus LFSR, tags each
// adder result with a sequence index, buffers it and streams it into the write master.
module lfsr_capture_packer #(
  parameter int SAMPLE_WIDTH   = 27,
  parameter int DATAWIDTH      = 32,
  parameter int ADDRESSWIDTH   = 32,
  parameter int COUNT_WIDTH    = 14,
  parameter int FIFODEPTH      = 16,
  parameter int FIFODEPTH_LOG2 = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [ADDRESSWIDTH-1:0] base_address,
  input  logic [COUNT_WIDTH-1:0]  sample_count,
  input  logic [SAMPLE_WIDTH-1:0] sample_data,
  output logic                    source_enable,
  output logic                    control_fixed_location,
  output logic [ADDRESSWIDTH-1:0] control_write_base,
  output logic [ADDRESSWIDTH-1:0] control_write_length,
  output logic                    control_go,
  input  logic                    control_done,
  output logic                    user_write_buffer,
  output logic [DATAWIDTH-1:0]    user_buffer_data,
  input  logic                    user_buffer_full,
  output logic                    busy,
  output logic                    done
);

  localparam int TAG_W = DATAWIDTH - SAMPLE_WIDTH;
  localparam int IDX_W = (TAG_W > 0) ? TAG_W : 1;
  localparam logic [ADDRESSWIDTH-1:0]   BYTES_PER_WORD = ADDRESSWIDTH'(DATAWIDTH / 8);
  localparam logic [FIFODEPTH_LOG2:0]   FULL_LEVEL     = (FIFODEPTH_LOG2 + 1)'(FIFODEPTH);

  typedef enum logic [2:0] {IDLE, GO, CAPTURE, DRAIN, WAIT_DONE} state_t;

  state_t                  state_q, state_d;
  logic [COUNT_WIDTH-1:0]  count_q, count_d;
  logic [COUNT_WIDTH-1:0]  captured_q, captured_d;
  logic [IDX_W-1:0]        index_q, index_d;
  logic [ADDRESSWIDTH-1:0] base_q, base_d;
  logic [ADDRESSWIDTH-1:0] length_q, length_d;
  logic                    done_q, done_d;

  logic [DATAWIDTH-1:0]      mem [FIFODEPTH];
  logic [FIFODEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFODEPTH_LOG2:0]   level_q, level_d;
  logic                      fifo_empty, fifo_full, push, pop;
  logic [DATAWIDTH-1:0]      push_word;

  generate
    if (TAG_W > 0) begin : g_tag
      assign push_word = {index_q, sample_data};
    end else begin : g_no_tag
      assign push_word = sample_data;
    end
  endgenerate

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == FULL_LEVEL);
  assign push       = (state_q == CAPTURE) && (captured_q < count_q) && !fifo_full;
  assign pop        = !fifo_empty && !user_buffer_full;

  assign source_enable          = push;
  assign user_write_buffer      = pop;
  // Head is masked while empty so the data bus reads zero after reset.
  assign user_buffer_data       = fifo_empty ? '0 : mem[rd_ptr_q];
  assign control_go             = (state_q == GO);
  assign busy                   = (state_q != IDLE);
  assign done                   = done_q;
  assign control_fixed_location = 1'b0;
  assign control_write_base     = base_q;
  assign control_write_length   = length_q;

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    captured_d = captured_q;
    index_d    = index_q;
    base_d     = base_q;
    length_d   = length_q;
    done_d     = 1'b0;
    if (push) begin
      captured_d = captured_q + 1'b1;
      index_d    = index_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          if (sample_count != '0) begin
            base_d     = base_address;
            count_d    = sample_count;
            length_d   = ADDRESSWIDTH'(sample_count) * BYTES_PER_WORD;
            captured_d = '0;
            index_d    = '0;
            state_d    = GO;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      GO:      state_d = CAPTURE;
      CAPTURE: if (captured_d == count_q) state_d = DRAIN;
      // Leave only once the final pop has landed, so the master holds every word.
      DRAIN:   if (level_d == '0) state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (control_done) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      captured_q <= '0;
      index_q    <= '0;
      base_q     <= '0;
      length_q   <= '0;
      done_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      captured_q <= captured_d;
      index_q    <= index_d;
      base_q     <= base_d;
      length_q   <= length_d;
      done_q     <= done_d;
      level_q    <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_word;
  end

endmodule

// File: tb/tb_lfsr_capture_packer.sv
// Scoreboard bench for lfsr_capture_packer: expected words are queued as samples are
// enabled and compared as the design pushes them into the write-master buffer.
module tb_lfsr_capture_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] base_address;
  logic [13:0] sample_count;
  logic [26:0] sample_data;
  logic        source_enable;
  logic        control_fixed_location;
  logic [31:0] control_write_base;
  logic [31:0] control_write_length;
  logic        control_go;
  logic        control_done;
  logic        user_write_buffer;
  logic [31:0] user_buffer_data;
  logic        user_buffer_full;
  logic        busy;
  logic        done;

  lfsr_capture_packer dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .start                  (start),
    .base_address           (base_address),
    .sample_count           (sample_count),
    .sample_data            (sample_data),
    .source_enable          (source_enable),
    .control_fixed_location (control_fixed_location),
    .control_write_base     (control_write_base),
    .control_write_length   (control_write_length),
    .control_go             (control_go),
    .control_done           (control_done),
    .user_write_buffer      (user_write_buffer),
    .user_buffer_data       (user_buffer_data),
    .user_buffer_full       (user_buffer_full),
    .busy                   (busy),
    .done                   (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int se_cnt = 0, pop_cnt = 0, go_cnt = 0, done_cnt = 0;
  logic [4:0]  exp_tag = '0;
  logic [31:0] sb[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    sample_data = '0;
    forever begin
      @(posedge clk);
      #1 sample_data = 27'($urandom);
    end
  end

  // Monitor: pop/compare before pushing, since a word can never be popped in its capture cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      if (user_buffer_full) check("no_push_full", user_write_buffer, 0);
      if (user_write_buffer) begin
        pop_cnt++;
        if (sb.size() == 0) check("sb_underflow", 1, 0);
        else check("word", user_buffer_data, sb.pop_front());
        $display("push word %08h (tag %0d)", user_buffer_data, user_buffer_data[31:27]);
      end
      if (source_enable) begin
        sb.push_back({exp_tag, sample_data});
        exp_tag++;
        se_cnt++;
      end
      if (control_go) go_cnt++;
      if (done) done_cnt++;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_se"},   source_enable, 0);
    check({tag, "_go"},   control_go, 0);
    check({tag, "_uwb"},  user_write_buffer, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_base"}, control_write_base, 0);
    check({tag, "_len"},  control_write_length, 0);
    check({tag, "_data"}, user_buffer_data, 0);
    check({tag, "_fix"},  control_fixed_location, 0);
  endtask

  // Leaves the bench 1ns into the first capture cycle (T+2).
  task automatic start_run(input logic [31:0] base, input logic [13:0] cnt);
    se_cnt = 0; pop_cnt = 0; go_cnt = 0; done_cnt = 0; exp_tag = '0;
    @(posedge clk); #1;
    start = 1'b1; base_address = base; sample_count = cnt;
    @(posedge clk); #1;
    start = 1'b0;
    check("go_pulse", control_go, 1);
    check("go_busy", busy, 1);
    check("go_base", control_write_base, base);
    check("go_len", control_write_length, 32'(cnt) * 4);
    @(posedge clk); #1;
    check("first_se", source_enable, 1);
    check("go_single", control_go, 0);
  endtask

  task automatic finish_run(input int cnt, input int done_delay);
    int guard = 0;
    while (pop_cnt < cnt && guard < 3000) begin
      @(posedge clk);
      guard++;
    end
    #1;
    check("drained", pop_cnt, cnt);
    check("se_cycles", se_cnt, cnt);
    check("sb_empty", sb.size(), 0);
    check("go_count", go_cnt, 1);
    check("no_early_done", done_cnt, 0);
    repeat (done_delay) @(posedge clk);
    #1 control_done = 1'b1;
    @(posedge clk); #1;
    control_done = 1'b0;
    check("done_pulse", done, 1);
    check("busy_fall", busy, 0);
    @(posedge clk); #1;
    check("done_single", done, 0);
    check("done_count", done_cnt, 1);
    $display("run of %0d samples complete", cnt);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; base_address = '0; sample_count = '0;
    control_done = 1'b0; user_buffer_full = 1'b0;
    #2 check_all_zero("reset");
    #5 reset_n = 1'b1;

    // Basic run
    start_run(32'h1000, 14'd4);
    finish_run(4, 3);

    // Backpressure with tag wrap
    user_buffer_full = 1'b1;
    start_run(32'h2000, 14'd40);
    repeat (28) @(posedge clk);
    #1;
    check("bp_captured", se_cnt, 16);
    check("bp_se_low", source_enable, 0);
    check("bp_no_pop", pop_cnt, 0);
    user_buffer_full = 1'b0;
    finish_run(40, 2);

    // Zero count
    go_cnt = 0; done_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; sample_count = '0; base_address = 32'hdead0000;
    @(posedge clk); #1;
    start = 1'b0;
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    check("zero_go", control_go, 0);
    @(posedge clk); #1;
    check("zero_done_single", done, 0);
    check("zero_go_count", go_cnt, 0);
    check("zero_busy_after", busy, 0);

    // Start while busy
    start_run(32'h3000, 14'd6);
    start = 1'b1; base_address = 32'h7000; sample_count = 14'd9;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_start_base", control_write_base, 32'h3000);
    check("busy_start_len", control_write_length, 24);
    finish_run(6, 1);

    // Early control_done during capture
    start_run(32'h4000, 14'd6);
    control_done = 1'b1;
    @(posedge clk); #1;
    control_done = 1'b0;
    check("early_cd_ignored", done, 0);
    check("early_cd_busy", busy, 1);
    finish_run(6, 2);

    // Async reset mid-run
    start_run(32'h5000, 14'd10);
    begin
      int guard = 0;
      while (se_cnt < 5 && guard < 100) begin
        @(posedge clk);
        guard++;
      end
    end
    #2 reset_n = 1'b0;
    #1 check_all_zero("midreset");
    sb.delete();
    done_cnt = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("reset_no_done", done_cnt, 0);
    check("reset_idle", busy, 0);
    start_run(32'h6000, 14'd2);
    finish_run(2, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
